// File: rtl/wb_stage_if.sv
// MEM -> WB retire handshake and instruction payload.
//   master : MEM stage drives mem_valid and the payload, samples mem_ready
//   slave  : writeback stage samples the payload, drives mem_ready
interface wb_stage_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_wbtype;
  logic        mem_is_load;
  logic        mem_sign;
  logic [1:0]  mem_addr_off;
  logic [31:0] mem_result;

  modport master (
    output mem_valid, mem_rd, mem_wbtype, mem_is_load, mem_sign, mem_addr_off, mem_result,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_rd, mem_wbtype, mem_is_load, mem_sign, mem_addr_off, mem_result,
    output mem_ready
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: retires instructions from MEM, waits for data-memory responses on
// loads, extracts/extends byte and half loads, and issues one register-file write per
// retired instruction. All outputs are registered.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem             retire handshake + payload (wb_stage_if.slave)
//   dm_rvalid/rdata data-memory read response (single-cycle pulse, aligned word)
//   write_reg/write_data/Regwrite  register-file write port (Regwrite=000 means no write)
//   waiting         load response outstanding
//   pend_valid/pend_rd  destination of the outstanding load, for hazard logic
//   load_err        one-cycle pulse when a load is abandoned on timeout
module wb_stage #(
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  wb_stage_if.slave   mem,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic [2:0]  Regwrite,
  output logic        waiting,
  output logic        pend_valid,
  output logic [4:0]  pend_rd,
  output logic        load_err
);

  localparam int unsigned RW   = 5;
  localparam int unsigned XLEN = 32;
  localparam int unsigned TW   = 3;

  localparam logic [TW-1:0]    WB_NONE = 3'b000;
  localparam logic [TW-1:0]    WB_HALF = 3'b011;
  localparam logic [TW-1:0]    WB_BYTE = 3'b001;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [RW-1:0]     ld_rd, ld_rd_nx;
  logic [TW-1:0]     ld_type, ld_type_nx;
  logic              ld_sign, ld_sign_nx;
  logic [1:0]        ld_off, ld_off_nx;

  logic [RW-1:0]     write_reg_nx;
  logic [XLEN-1:0]   write_data_nx;
  logic [TW-1:0]     regwrite_nx;
  logic              waiting_nx, pend_valid_nx, load_err_nx, mem_ready_nx;
  logic [RW-1:0]     pend_rd_nx;

  // Byte/half selection from the aligned word plus sign/zero extension.
  function automatic logic [XLEN-1:0] extract(input logic [TW-1:0] t, input logic s,
                                              input logic [1:0] off, input logic [XLEN-1:0] d);
    logic [15:0] h;
    logic [7:0]  b;
    h = off[1] ? d[31:16] : d[15:0];
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    case (t)
      WB_HALF: extract = {{16{s & h[15]}}, h};
      WB_BYTE: extract = {{24{s & b[7]}}, b};
      default: extract = d;
    endcase
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    ld_rd_nx      = ld_rd;
    ld_type_nx    = ld_type;
    ld_sign_nx    = ld_sign;
    ld_off_nx     = ld_off;
    write_reg_nx  = '0;
    write_data_nx = '0;
    regwrite_nx   = WB_NONE;
    waiting_nx    = waiting;
    pend_valid_nx = pend_valid;
    pend_rd_nx    = pend_rd;
    load_err_nx   = 1'b0;

    case (state)
      IDLE: begin
        // dm_rvalid is deliberately ignored here: it can only be a late/stray response.
        if (mem.mem_valid) begin
          if (mem.mem_is_load) begin
            ld_rd_nx      = mem.mem_rd;
            ld_type_nx    = mem.mem_wbtype;
            ld_sign_nx    = mem.mem_sign;
            ld_off_nx     = mem.mem_addr_off;
            cnt_nx        = '0;
            state_nx      = WAIT_LOAD;
            waiting_nx    = 1'b1;
            pend_valid_nx = 1'b1;
            pend_rd_nx    = mem.mem_rd;
          end else if (mem.mem_wbtype != WB_NONE && mem.mem_rd != '0) begin
            write_reg_nx  = mem.mem_rd;
            write_data_nx = mem.mem_result;
            regwrite_nx   = mem.mem_wbtype;
          end
        end
      end
      WAIT_LOAD: begin
        // A response on the final timeout cycle still wins over the timeout.
        if (dm_rvalid) begin
          state_nx      = IDLE;
          waiting_nx    = 1'b0;
          pend_valid_nx = 1'b0;
          pend_rd_nx    = '0;
          if (ld_type != WB_NONE && ld_rd != '0) begin
            write_reg_nx  = ld_rd;
            write_data_nx = extract(ld_type, ld_sign, ld_off, dm_rdata);
            regwrite_nx   = ld_type;
          end
        end else if (cnt == TO_LAST) begin
          state_nx      = IDLE;
          waiting_nx    = 1'b0;
          pend_valid_nx = 1'b0;
          pend_rd_nx    = '0;
          load_err_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    mem_ready_nx = (state_nx == IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      ld_rd         <= '0;
      ld_type       <= WB_NONE;
      ld_sign       <= 1'b0;
      ld_off        <= '0;
      write_reg     <= '0;
      write_data    <= '0;
      Regwrite      <= WB_NONE;
      waiting       <= 1'b0;
      pend_valid    <= 1'b0;
      pend_rd       <= '0;
      load_err      <= 1'b0;
      mem.mem_ready <= 1'b1;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      ld_rd         <= ld_rd_nx;
      ld_type       <= ld_type_nx;
      ld_sign       <= ld_sign_nx;
      ld_off        <= ld_off_nx;
      write_reg     <= write_reg_nx;
      write_data    <= write_data_nx;
      Regwrite      <= regwrite_nx;
      waiting       <= waiting_nx;
      pend_valid    <= pend_valid_nx;
      pend_rd       <= pend_rd_nx;
      load_err      <= load_err_nx;
      mem.mem_ready <= mem_ready_nx;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected register writes are queued when the
// producing stimulus is driven and popped when the DUT presents a write.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [2:0]  Regwrite;
  logic        waiting, pend_valid, load_err;
  logic [4:0]  pend_rd;

  wb_stage_if mif ();

  wb_stage #(.TIMEOUT_CYC(15), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (mif.slave),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .write_reg  (write_reg),
    .write_data (write_data),
    .Regwrite   (Regwrite),
    .waiting    (waiting),
    .pend_valid (pend_valid),
    .pend_rd    (pend_rd),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [2:0]  t;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Write monitor: every nonzero Regwrite must match the head of the scoreboard.
  always @(negedge clk) begin
    if (cyc > 0 && !rst) begin
      if (Regwrite !== 3'b000) begin
        if (sb.size() == 0) begin
          check("unexpected_write", {27'd0, write_reg}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wr_reg", {27'd0, write_reg}, {27'd0, e.rd});
          check("wr_data", write_data, e.data);
          check("wr_type", {29'd0, Regwrite}, {29'd0, e.t});
          check("wr_cycle", 32'(cyc), 32'(e.due));
        end
      end else begin
        check("idle_reg", {27'd0, write_reg}, 32'd0);
        check("idle_data", write_data, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step();
    mif.mem_valid = 1'b0;
    dm_rvalid     = 1'b0;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] data, input logic [2:0] t);
    exp_t e;
    e.rd = rd; e.data = data; e.t = t; e.due = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic chk_status(input logic w, input logic pv, input logic [4:0] prd,
                            input logic rdy, input logic lerr);
    check("waiting", {31'd0, waiting}, {31'd0, w});
    check("pend_valid", {31'd0, pend_valid}, {31'd0, pv});
    if (pv) check("pend_rd", {27'd0, pend_rd}, {27'd0, prd});
    check("mem_ready", {31'd0, mif.mem_ready}, {31'd0, rdy});
    check("load_err", {31'd0, load_err}, {31'd0, lerr});
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] t, input logic ld,
                       input logic s, input logic [1:0] off, input logic [31:0] res);
    step();
    dm_rvalid        = 1'b0;
    check("ready_at_issue", {31'd0, mif.mem_ready}, 32'd1);
    mif.mem_valid    = 1'b1;
    mif.mem_rd       = rd;
    mif.mem_wbtype   = t;
    mif.mem_is_load  = ld;
    mif.mem_sign     = s;
    mif.mem_addr_off = off;
    mif.mem_result   = res;
    if (!ld && t != 3'b000 && rd != 5'd0) push(rd, res, t);
  endtask

  // Load whose response arrives during the 'delay'-th wait cycle.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] t, input logic s,
                         input logic [1:0] off, input logic [31:0] rdata,
                         input logic [31:0] exp, input int delay);
    issue(rd, t, 1'b1, s, off, 32'h0);
    for (int i = 1; i < delay; i++) begin
      idle();
      chk_status(1'b1, 1'b1, rd, 1'b0, 1'b0);
    end
    step();
    mif.mem_valid = 1'b0;
    chk_status(1'b1, 1'b1, rd, 1'b0, 1'b0);
    dm_rvalid = 1'b1;
    dm_rdata  = rdata;
    if (t != 3'b000 && rd != 5'd0) push(rd, exp, t);
    idle();
    chk_status(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    dm_rvalid = 1'b0;
    dm_rdata = 32'h0;
    mif.mem_valid = 1'b0;
    mif.mem_rd = 5'd0;
    mif.mem_wbtype = 3'b000;
    mif.mem_is_load = 1'b0;
    mif.mem_sign = 1'b0;
    mif.mem_addr_off = 2'd0;
    mif.mem_result = 32'h0;
    step();
    step();
    chk_status(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    check("rst_write_reg", {27'd0, write_reg}, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_regwrite", {29'd0, Regwrite}, 32'd0);
    rst = 1'b0;

    // ALU write, one-cycle pulse
    issue(5'd5, 3'b111, 1'b0, 1'b0, 2'd0, 32'hDEADBEEF);
    idle();
    idle();

    // LB off=3 signed, response in 4th wait cycle
    do_load(5'd3, 3'b001, 1'b1, 2'd3, 32'h80FF1234, 32'hFFFFFF80, 4);
    // back-to-back loads and extraction variants
    do_load(5'd4, 3'b011, 1'b0, 2'd2, 32'h9ABC0000, 32'h00009ABC, 2);
    do_load(5'd6, 3'b011, 1'b1, 2'd2, 32'h9ABC0000, 32'hFFFF9ABC, 1);
    do_load(5'd0, 3'b111, 1'b0, 2'd0, 32'h55555555, 32'h0, 2);
    do_load(5'd8, 3'b001, 1'b0, 2'd3, 32'h80FF1234, 32'h00000080, 1);
    do_load(5'd9, 3'b001, 1'b1, 2'd1, 32'h80FF1234, 32'h00000012, 3);
    do_load(5'd12, 3'b011, 1'b1, 2'd1, 32'h80FF1234, 32'h00001234, 1);
    do_load(5'd13, 3'b111, 1'b1, 2'd0, 32'h80FF1234, 32'h80FF1234, 2);
    idle();

    // Timeout: 15 wait cycles with no response
    issue(5'd9, 3'b111, 1'b1, 1'b0, 2'd0, 32'h0);
    for (int i = 1; i <= 15; i++) begin
      idle();
      chk_status(1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    end
    idle();
    chk_status(1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
    idle();
    chk_status(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    step();
    dm_rvalid = 1'b1;
    dm_rdata  = 32'h11112222;
    idle();
    idle();

    // Response on the final timeout cycle wins
    do_load(5'd10, 3'b111, 1'b0, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D, 15);
    idle();

    // Reset during the second wait cycle drops the load
    issue(5'd11, 3'b111, 1'b1, 1'b0, 2'd0, 32'h0);
    idle();
    idle();
    rst = 1'b1;
    step();
    chk_status(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    check("rstw_write_reg", {27'd0, write_reg}, 32'd0);
    check("rstw_regwrite", {29'd0, Regwrite}, 32'd0);
    rst = 1'b0;
    dm_rvalid = 1'b1;
    dm_rdata  = 32'h77778888;
    idle();
    idle();

    // Store then ALU to the same rd, back-to-back
    issue(5'd7, 3'b000, 1'b0, 1'b0, 2'd0, 32'hAAAA5555);
    issue(5'd7, 3'b111, 1'b0, 1'b0, 2'd0, 32'h12345678);
    idle();
    idle();
    idle();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
